// File: rtl/addr_decoder_pkg.sv
// Shared types and constants for the address window decoder: bus FSM states,
// default parameter values and the boot-ROM window restored at reset.
package addr_decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BERR   = 2'd2
    } bus_state_e;

    localparam int DEF_NUM_REGIONS    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] BOOT_ROM_MASK = 32'hFFFF_8000;

    // A disabled watchdog (limit 0) still needs a 1-bit counter to stay legal.
    function automatic int wd_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles up to a limit, never wraps, and
// flags the cycle whose increment would reach the limit.
module bus_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i && (count_q != limit_i))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Flag on the increment that lands on the limit so the owner can leave
    // on that same edge; limit 0 never expires.
    assign expired_o = enable_i && !clear_i && (limit_i != '0) &&
                       (count_q == limit_i - W'(1));

endmodule

// File: rtl/address_window_decoder.sv
// Programmable address window decoder with one-hot region select, bus error
// generation on miss or watchdog timeout, and error logging.
module address_window_decoder
    import addr_decoder_pkg::*;
#(
    parameter int NUM_REGIONS    = DEF_NUM_REGIONS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_H,
    input  logic [31:0]            Address,
    input  logic                   AS_L,
    input  logic                   DTACK_L,
    input  logic                   CfgWrite_H,
    input  logic [IDX_W-1:0]       CfgIndex,
    input  logic [31:0]            CfgBase,
    input  logic [31:0]            CfgMask,
    input  logic                   CfgEnable_H,
    output logic [NUM_REGIONS-1:0] RegionSelect_H,
    output logic                   BusError_L,
    output logic [7:0]             ErrorCount,
    output logic [31:0]            LastErrorAddress
);

    localparam int             WD_W     = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [NUM_REGIONS-1:0][31:0] base_q, mask_q;
    logic [NUM_REGIONS-1:0]       en_q;

    bus_state_e             state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic                   acked_q, acked_d;
    logic [7:0]             ecnt_q, ecnt_d;
    logic [31:0]            laddr_q, laddr_d;

    logic [NUM_REGIONS-1:0] hit, hit_sel;
    logic                   cfg_ok;
    logic                   wd_clear, wd_enable, wd_expired;

    assign cfg_ok = CfgWrite_H && (32'(CfgIndex) < 32'(NUM_REGIONS));

    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            base_q    <= '0;
            mask_q    <= '0;
            en_q      <= '0;
            base_q[0] <= BOOT_ROM_BASE;
            mask_q[0] <= BOOT_ROM_MASK;
            en_q[0]   <= 1'b1;
        end else if (cfg_ok) begin
            base_q[CfgIndex] <= CfgBase;
            mask_q[CfgIndex] <= CfgMask;
            en_q[CfgIndex]   <= CfgEnable_H;
        end
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_win
        assign hit[g] = en_q[g] && ((Address & mask_q[g]) == (base_q[g] & mask_q[g]));
    end

    // Isolate the lowest set bit: lowest-index window wins, result is one-hot.
    assign hit_sel = hit & (~hit + NUM_REGIONS'(1));

    bus_timeout_counter #(.W(WD_W)) u_wd (
        .clk_i     (Clk),
        .rst_i     (Reset_H),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (WD_LIMIT),
        .expired_o (wd_expired)
    );

    // Watchdog only runs while the access is waiting for its first DTACK.
    assign wd_enable = (state_q == S_ACTIVE) && DTACK_L && !acked_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        acked_d  = acked_q;
        ecnt_d   = ecnt_q;
        laddr_d  = laddr_q;
        wd_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                wd_clear = 1'b1;
                acked_d  = 1'b0;
                if (!AS_L) begin
                    if (|hit_sel) begin
                        sel_d   = hit_sel;
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_BERR;
                    end
                end
            end
            S_ACTIVE: begin
                if (!DTACK_L)
                    acked_d = 1'b1;
                if (AS_L) begin
                    sel_d   = '0;
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    sel_d   = '0;
                    state_d = S_BERR;
                end
            end
            S_BERR: begin
                if (AS_L) begin
                    sel_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sel_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        if ((state_d == S_BERR) && (state_q != S_BERR)) begin
            if (ecnt_q != 8'hFF)
                ecnt_d = ecnt_q + 8'd1;
            laddr_d = Address;
        end
    end

    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            acked_q <= 1'b0;
            ecnt_q  <= '0;
            laddr_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            acked_q <= acked_d;
            ecnt_q  <= ecnt_d;
            laddr_q <= laddr_d;
        end
    end

    assign RegionSelect_H   = sel_q;
    assign BusError_L       = (state_q != S_BERR);
    assign ErrorCount       = ecnt_q;
    assign LastErrorAddress = laddr_q;

endmodule

// File: tb/tb_address_window_decoder.sv
// Directed bench for address_window_decoder with a transaction-level model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_address_window_decoder;

    localparam int NR = 8;
    localparam int TO = 4;

    logic          Clk, Reset_H;
    logic [31:0]   Address;
    logic          AS_L, DTACK_L, CfgWrite_H, CfgEnable_H;
    logic [2:0]    CfgIndex;
    logic [31:0]   CfgBase, CfgMask;
    logic [NR-1:0] RegionSelect_H;
    logic          BusError_L;
    logic [7:0]    ErrorCount;
    logic [31:0]   LastErrorAddress;

    address_window_decoder #(.NUM_REGIONS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .AS_L(AS_L),
        .DTACK_L(DTACK_L), .CfgWrite_H(CfgWrite_H), .CfgIndex(CfgIndex),
        .CfgBase(CfgBase), .CfgMask(CfgMask), .CfgEnable_H(CfgEnable_H),
        .RegionSelect_H(RegionSelect_H), .BusError_L(BusError_L),
        .ErrorCount(ErrorCount), .LastErrorAddress(LastErrorAddress)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: table, access in progress, waited cycles,
    // error flag and error log.
    logic [31:0] m_base [NR];
    logic [31:0] m_mask [NR];
    bit          m_en   [NR];
    logic [7:0]  m_sel;
    bit          m_busy, m_berr, m_acked;
    int          m_wait, m_ecnt;
    logic [31:0] m_laddr;

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NR; i++)
            if (m_en[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i])))
                return i;
        return -1;
    endfunction

    always @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            for (int i = 0; i < NR; i++) begin
                m_base[i] <= 32'h0;
                m_mask[i] <= (i == 0) ? 32'hFFFF8000 : 32'h0;
                m_en[i]   <= (i == 0);
            end
            m_sel <= '0; m_busy <= 0; m_berr <= 0; m_acked <= 0;
            m_wait <= 0; m_ecnt <= 0; m_laddr <= '0;
        end else begin
            if (!m_busy && !m_berr) begin
                if (!AS_L) begin
                    if (model_decode(Address) >= 0) begin
                        m_busy <= 1; m_wait <= 0; m_acked <= 0;
                        m_sel  <= 8'b1 << model_decode(Address);
                    end else begin
                        m_berr  <= 1;
                        m_ecnt  <= (m_ecnt == 255) ? 255 : m_ecnt + 1;
                        m_laddr <= Address;
                    end
                end
            end else if (m_busy) begin
                if (AS_L) begin
                    m_busy <= 0; m_sel <= '0;
                end else if (!m_acked) begin
                    if (!DTACK_L)
                        m_acked <= 1;
                    else if (m_wait + 1 == TO) begin
                        m_busy  <= 0; m_sel <= '0; m_berr <= 1;
                        m_ecnt  <= (m_ecnt == 255) ? 255 : m_ecnt + 1;
                        m_laddr <= Address;
                    end else
                        m_wait <= m_wait + 1;
                end
            end else if (AS_L) begin
                m_berr <= 0;
            end
            if (CfgWrite_H && (int'(CfgIndex) < NR)) begin
                m_base[CfgIndex] <= CfgBase;
                m_mask[CfgIndex] <= CfgMask;
                m_en[CfgIndex]   <= CfgEnable_H;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("model_sel",   32'(RegionSelect_H), 32'(m_sel));
            check("model_berr",  32'(BusError_L), m_berr ? 32'd0 : 32'd1);
            check("model_ecnt",  32'(ErrorCount), 32'(m_ecnt));
            check("model_laddr", LastErrorAddress, m_laddr);
        end
    end

    task automatic cfg(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] m, input logic e);
        @(negedge Clk);
        CfgWrite_H = 1; CfgIndex = idx; CfgBase = b; CfgMask = m; CfgEnable_H = e;
        @(negedge Clk);
        CfgWrite_H = 0;
    endtask

    // Returns at the first negedge after AS_L was sampled low.
    task automatic start(input logic [31:0] a);
        @(negedge Clk);
        Address = a; AS_L = 0;
        @(negedge Clk);
    endtask

    task automatic finish_acc();
        DTACK_L = 0;
        @(negedge Clk);
        AS_L = 1; DTACK_L = 1;
        @(negedge Clk);
    endtask

    initial begin
        Reset_H = 1; Address = '0; AS_L = 1; DTACK_L = 1;
        CfgWrite_H = 0; CfgIndex = '0; CfgBase = '0; CfgMask = '0; CfgEnable_H = 0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_H = 0;
        chk_en  = 1;
        check("rst_sel", 32'(RegionSelect_H), 32'h0);
        check("rst_berr", 32'(BusError_L), 32'h1);
        check("rst_ecnt", 32'(ErrorCount), 32'h0);
        check("rst_laddr", LastErrorAddress, 32'h0);

        // Boot ROM window
        start(32'h0000_1000);
        check("boot_sel", 32'(RegionSelect_H), 32'h01);
        finish_acc();
        check("boot_sel_clr", 32'(RegionSelect_H), 32'h00);

        // Window 3 hit, then just past its end
        cfg(3'd3, 32'h0800_0000, 32'hFC00_0000, 1'b1);
        start(32'h0BFF_FFFC);
        check("w3_sel", 32'(RegionSelect_H), 32'h08);
        finish_acc();
        start(32'h0C00_0000);
        check("miss_berr", 32'(BusError_L), 32'h0);
        check("miss_sel", 32'(RegionSelect_H), 32'h0);
        check("miss_ecnt", 32'(ErrorCount), 32'd1);
        check("miss_laddr", LastErrorAddress, 32'h0C00_0000);
        finish_acc();
        check("miss_release", 32'(BusError_L), 32'h1);

        // Overlap: lowest index wins
        cfg(3'd5, 32'h0040_0000, 32'hFFC0_0000, 1'b1);
        cfg(3'd2, 32'h0040_0000, 32'hFFC0_0000, 1'b1);
        start(32'h0040_0000);
        check("overlap_sel", 32'(RegionSelect_H), 32'h04);
        finish_acc();

        // Watchdog expiry after four waiting cycles
        start(32'h0000_1000);
        check("wd_sel", 32'(RegionSelect_H), 32'h01);
        repeat (3) @(negedge Clk);
        check("wd_not_yet", 32'(BusError_L), 32'h1);
        @(negedge Clk);
        check("wd_berr", 32'(BusError_L), 32'h0);
        check("wd_ecnt", 32'(ErrorCount), 32'd2);
        finish_acc();

        // DTACK in cycle 2 freezes the watchdog
        start(32'h0000_1000);
        @(negedge Clk); DTACK_L = 0;
        @(negedge Clk); DTACK_L = 1;
        repeat (5) @(negedge Clk);
        check("wd_frozen", 32'(BusError_L), 32'h1);
        check("wd_frozen_sel", 32'(RegionSelect_H), 32'h01);
        finish_acc();

        // Table write during an access leaves the held select alone
        cfg(3'd1, 32'h1000_0000, 32'hF000_0000, 1'b1);
        start(32'h1000_0001);
        @(negedge Clk);
        CfgWrite_H = 1; CfgIndex = 3'd1; CfgEnable_H = 0;
        @(negedge Clk);
        CfgWrite_H = 0;
        check("active_write_sel", 32'(RegionSelect_H), 32'h02);
        finish_acc();

        // Asynchronous reset while in BERR
        start(32'h0C00_0000);
        check("pre_rst_berr", 32'(BusError_L), 32'h0);
        check("pre_rst_ecnt", 32'(ErrorCount), 32'd3);
        #2 Reset_H = 1;
        #1;
        check("async_berr", 32'(BusError_L), 32'h1);
        check("async_ecnt", 32'(ErrorCount), 32'h0);
        check("async_laddr", LastErrorAddress, 32'h0);
        @(negedge Clk);
        AS_L = 1; Reset_H = 0;
        start(32'h0000_1000);
        check("restored_w0", 32'(RegionSelect_H), 32'h01);
        finish_acc();
        start(32'h0BFF_FFFC);
        check("w3_cleared", 32'(BusError_L), 32'h0);
        check("w3_cleared_ecnt", 32'(ErrorCount), 32'd1);
        finish_acc();

        // Write and decode in the same cycle use the old entry
        @(negedge Clk);
        CfgWrite_H = 1; CfgIndex = 3'd1; CfgBase = 32'h2000_0000;
        CfgMask = 32'hF000_0000; CfgEnable_H = 1;
        Address = 32'h2000_0000; AS_L = 0;
        @(negedge Clk);
        CfgWrite_H = 0;
        check("same_cycle_miss", 32'(BusError_L), 32'h0);
        AS_L = 1;
        @(negedge Clk);
        start(32'h2000_0000);
        check("repeat_hit", 32'(RegionSelect_H), 32'h02);
        finish_acc();

        // Error counter saturation
        repeat (260) begin
            @(negedge Clk); Address = 32'hF000_0000; AS_L = 0;
            @(negedge Clk); AS_L = 1;
        end
        @(negedge Clk);
        check("ecnt_sat", 32'(ErrorCount), 32'd255);
        check("sat_laddr", LastErrorAddress, 32'hF000_0000);

        @(negedge Clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/address_window_decoder.md
ADDRESS_WINDOW_DECODER -- requirements
Module: address_window_decoder

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 8, number of programmable decode windows (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-cycle watchdog limit in Clk cycles; 0 disables the watchdog.
REQ-003 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Reset_H  input  1  asynchronous, active-high reset.
REQ-005 Address  input  32  CPU byte address, valid while AS_L low.
REQ-006 AS_L  input  1  CPU address strobe, active low.
REQ-007 DTACK_L  input  1  combined slave acknowledge, active low.
REQ-008 CfgWrite_H  input  1  one-cycle window-table write strobe.
REQ-009 CfgIndex  input  clog2(NUM_REGIONS)  window number to write.
REQ-010 CfgBase, CfgMask  input  32 each  window base and compare mask.
REQ-011 CfgEnable_H  input  1  window enable written with base/mask.
REQ-012 RegionSelect_H  output  NUM_REGIONS  registered one-hot window select.
REQ-013 BusError_L  output  1  registered bus error to CPU, active low.
REQ-014 ErrorCount  output  8  saturating count of bus errors.
REQ-015 LastErrorAddress  output  32  Address captured at the most recent bus error.

Function
REQ-016 Window i SHALL hit when enabled and (Address AND Mask_i) equals (Base_i AND Mask_i).
REQ-017 Multiple hits SHALL resolve to the lowest index; RegionSelect_H SHALL never have more than one bit set.
REQ-018 FSM states SHALL be IDLE, ACTIVE, BERR.
REQ-019 IDLE: AS_L sampled low with a hit -> register one-hot select, clear watchdog, go ACTIVE (select visible one cycle after AS_L sampled low).
REQ-020 IDLE: AS_L sampled low with no hit -> RegionSelect_H stays 0, go BERR; BusError_L low the next cycle.
REQ-021 ACTIVE: select held constant; watchdog increments each cycle DTACK_L is high; first DTACK_L low freezes it for the rest of the cycle.
REQ-022 ACTIVE: watchdog reaching TIMEOUT_CYCLES without DTACK -> clear select, go BERR.
REQ-023 ACTIVE or BERR: AS_L sampled high -> clear select, BusError_L high, go IDLE; AS_L high has priority over timeout in the same cycle.
REQ-024 BERR: BusError_L held low until AS_L sampled high.
REQ-025 Each entry into BERR SHALL increment ErrorCount (saturating at 255) and load LastErrorAddress.
REQ-026 Table writes SHALL take effect the cycle after CfgWrite_H; a decode in the same cycle uses the old entry.
REQ-027 Writes during ACTIVE SHALL not alter the held select; CfgIndex >= NUM_REGIONS SHALL be ignored.
REQ-028 Watchdog width SHALL be clog2(TIMEOUT_CYCLES+1) and SHALL never wrap.

Reset
REQ-029 Reset_H SHALL force IDLE, RegionSelect_H 0, BusError_L 1, ErrorCount 0, LastErrorAddress 0, watchdog 0, asynchronously, including mid-access.
REQ-030 Reset SHALL load window 0 = base 0x00000000, mask 0xFFFF8000, enabled (boot ROM); all others disabled, base/mask 0.

Structure
REQ-031 Shared package addr_decoder_pkg SHALL hold the FSM state enum, default parameter values and the boot-ROM base/mask constants.
REQ-032 Watchdog SHALL be a sub-module bus_timeout_counter (clear, enable, limit, expired).

Verification
REQ-033 After reset, AS_L low at 0x00001000 -> RegionSelect_H = 0x01 next cycle; DTACK then AS_L high -> 0x00.
REQ-034 Program window 3 base 0x08000000 mask 0xFC000000; access 0x0BFFFFFC -> 0x08; access 0x0C000000 -> BusError_L low, ErrorCount 1, LastErrorAddress 0x0C000000.
REQ-035 Windows 2 and 5 both cover 0x00400000; access -> RegionSelect_H = 0x04 only.
REQ-036 TIMEOUT_CYCLES=4, hit with DTACK_L high -> BusError_L low after 4 ACTIVE cycles; with DTACK low at cycle 2 -> no error.
REQ-037 Reset_H asserted during BERR -> BusError_L 1, ErrorCount 0, window 0 restored, immediately without clock.
REQ-038 CfgWrite_H to window 1 in the same cycle as decode of its new range -> miss (old entry); repeat access -> hit 0x02.
